// File: rtl/seletor_alternado_n_if.sv
// Bus between the memory-game controller and the operand selector that drives mux2x1_n.
// carrega/inicia are single-cycle strobes sampled on the rising edge. There is no ready signal:
// pronto (pair loaded) and ocupado (sequence running) tell the driver when a strobe will be accepted.
interface seletor_alternado_n_if #(
    parameter int BITS = 4
);
    logic            carrega;
    logic [BITS-1:0] dado_in;
    logic            inicia;
    logic [BITS-1:0] d0;
    logic [BITS-1:0] d1;
    logic            sel;
    logic            pronto;
    logic            ocupado;
    logic            fim;

    modport master (
        output carrega, dado_in, inicia,
        input  d0, d1, sel, pronto, ocupado, fim
    );

    modport slave (
        input  carrega, dado_in, inicia,
        output d0, d1, sel, pronto, ocupado, fim
    );
endinterface

// File: rtl/seletor_alternado_n.sv
// Loads an operand pair serially, then alternates the mux select between them
// for DURACAO cycles per slot, REPETICOES pairs, ending with a one-cycle fim pulse.
module seletor_alternado_n #(
    parameter int BITS       = 4,
    parameter int DURACAO    = 8,
    parameter int REPETICOES = 2
) (
    input  logic                 clock,
    input  logic                 reset,
    seletor_alternado_n_if.slave bus,
    output logic [1:0]           estado
);
    typedef enum logic [1:0] {
        OCIOSO  = 2'd0,
        EXIBE_A = 2'd1,
        EXIBE_B = 2'd2,
        FINAL   = 2'd3
    } estado_t;

    localparam int CW = (DURACAO > 1) ? $clog2(DURACAO) : 1;
    localparam int RW = (REPETICOES > 1) ? $clog2(REPETICOES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DURACAO - 1);
    localparam logic [RW-1:0] REP_MAX = RW'(REPETICOES - 1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [RW-1:0] REP_ONE = RW'(1);

    estado_t         st_q, st_n;
    logic [BITS-1:0] d0_q, d0_n, d1_q, d1_n;
    logic            sel_q, sel_n;
    logic            pronto_q, pronto_n;
    logic            ocup_q, ocup_n;
    logic            fim_q, fim_n;
    logic [1:0]      ptr_q, ptr_n;
    logic [CW-1:0]   cnt_q, cnt_n;
    logic [RW-1:0]   rep_q, rep_n;

    always_ff @(posedge clock) begin
        if (reset) begin
            st_q     <= OCIOSO;
            d0_q     <= '0;
            d1_q     <= '0;
            sel_q    <= 1'b0;
            pronto_q <= 1'b0;
            ocup_q   <= 1'b0;
            fim_q    <= 1'b0;
            ptr_q    <= 2'd0;
            cnt_q    <= '0;
            rep_q    <= '0;
        end else begin
            st_q     <= st_n;
            d0_q     <= d0_n;
            d1_q     <= d1_n;
            sel_q    <= sel_n;
            pronto_q <= pronto_n;
            ocup_q   <= ocup_n;
            fim_q    <= fim_n;
            ptr_q    <= ptr_n;
            cnt_q    <= cnt_n;
            rep_q    <= rep_n;
        end
    end

    always_comb begin
        st_n     = st_q;
        d0_n     = d0_q;
        d1_n     = d1_q;
        sel_n    = sel_q;
        pronto_n = pronto_q;
        ocup_n   = ocup_q;
        fim_n    = 1'b0;
        ptr_n    = ptr_q;
        cnt_n    = cnt_q;
        rep_n    = rep_q;
        case (st_q)
            OCIOSO: begin
                // A load always wins; an inicia in the same cycle is dropped.
                if (bus.carrega) begin
                    if (ptr_q == 2'd1) begin
                        d1_n     = bus.dado_in;
                        ptr_n    = 2'd2;
                        pronto_n = 1'b1;
                    end else begin
                        d0_n     = bus.dado_in;
                        ptr_n    = 2'd1;
                        pronto_n = 1'b0;
                    end
                end else if (bus.inicia && pronto_q) begin
                    st_n   = EXIBE_A;
                    ocup_n = 1'b1;
                    sel_n  = 1'b0;
                    cnt_n  = '0;
                    rep_n  = '0;
                end
            end
            EXIBE_A: begin
                if (cnt_q == CNT_MAX) begin
                    sel_n = 1'b1;
                    cnt_n = '0;
                    st_n  = EXIBE_B;
                end else begin
                    cnt_n = cnt_q + CNT_ONE;
                end
            end
            EXIBE_B: begin
                if (cnt_q == CNT_MAX) begin
                    sel_n = 1'b0;
                    cnt_n = '0;
                    if (rep_q == REP_MAX) begin
                        st_n   = FINAL;
                        ocup_n = 1'b0;
                        fim_n  = 1'b1;
                    end else begin
                        rep_n = rep_q + REP_ONE;
                        st_n  = EXIBE_A;
                    end
                end else begin
                    cnt_n = cnt_q + CNT_ONE;
                end
            end
            FINAL: begin
                // pronto is kept so the same pair can be replayed.
                st_n = OCIOSO;
            end
            default: st_n = OCIOSO;
        endcase
    end

    assign bus.d0      = d0_q;
    assign bus.d1      = d1_q;
    assign bus.sel     = sel_q;
    assign bus.pronto  = pronto_q;
    assign bus.ocupado = ocup_q;
    assign bus.fim     = fim_q;
    assign estado      = st_q;
endmodule

// File: tb/tb_seletor_alternado_n.sv
// Directed bench for seletor_alternado_n with BITS=4, DURACAO=3, REPETICOES=2.
// The driver pushes the expected output snapshot for each edge; a negedge monitor pops and compares.
module tb_seletor_alternado_n;
    localparam int W = 12;

    logic       clock;
    logic       reset;
    logic [1:0] estado;

    seletor_alternado_n_if #(.BITS(4)) bus ();

    seletor_alternado_n #(
        .BITS      (4),
        .DURACAO   (3),
        .REPETICOES(2)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus),
        .estado(estado)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    logic [W-1:0] exp_q[$];
    string        tag_q[$];
    int           n_checks = 0;
    int           n_fail   = 0;
    logic [W-1:0] exp_v;
    logic [W-1:0] act_v;
    string        tag_v;

    // Monitor: one snapshot {d0,d1,sel,pronto,ocupado,fim} per pushed edge.
    always @(negedge clock) begin
        if (exp_q.size() != 0) begin
            exp_v = exp_q.pop_front();
            tag_v = tag_q.pop_front();
            act_v = {bus.d0, bus.d1, bus.sel, bus.pronto, bus.ocupado, bus.fim};
            n_checks++;
            if (act_v !== exp_v) begin
                n_fail++;
                $display("FAIL %s: got d0=%b d1=%b sel=%b pronto=%b ocupado=%b fim=%b, expected d0=%b d1=%b sel=%b pronto=%b ocupado=%b fim=%b",
                         tag_v, act_v[11:8], act_v[7:4], act_v[3], act_v[2], act_v[1], act_v[0],
                         exp_v[11:8], exp_v[7:4], exp_v[3], exp_v[2], exp_v[1], exp_v[0]);
            end
        end
    end

    // One clock cycle: drive inputs, take the edge, record what must be visible after it.
    task automatic cyc(input string tag, input logic r, input logic c, input logic i,
                       input logic [3:0] d, input logic [3:0] e0, input logic [3:0] e1,
                       input logic es, input logic ep, input logic eo, input logic ef);
        reset       = r;
        bus.carrega = c;
        bus.inicia  = i;
        bus.dado_in = d;
        @(posedge clock);
        exp_q.push_back({e0, e1, es, ep, eo, ef});
        tag_q.push_back(tag);
        @(negedge clock);
    endtask

    // Full sequence with pair 1010/0101 loaded; carrega at E4 must be ignored,
    // and inicia+carrega during FINAL must be ignored too.
    task automatic run_seq(input string name);
        for (int k = 0; k < 12; k++) begin
            cyc($sformatf("%s k=%0d", name, k), 1'b0, (k == 4), (k == 0), 4'b1111,
                4'b1010, 4'b0101, (((k / 3) % 2) == 1), 1'b1, 1'b1, 1'b0);
        end
        cyc({name, " fim"},         1'b0, 1'b0, 1'b0, 4'b0000, 4'b1010, 4'b0101, 1'b0, 1'b1, 1'b0, 1'b1);
        cyc({name, " after fim"},   1'b0, 1'b1, 1'b1, 4'b1111, 4'b1010, 4'b0101, 1'b0, 1'b1, 1'b0, 1'b0);
        cyc({name, " idle"},        1'b0, 1'b0, 1'b0, 4'b0000, 4'b1010, 4'b0101, 1'b0, 1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        cyc("reset 1",          1'b1, 1'b0, 1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc("reset 2",          1'b1, 1'b0, 1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc("load a",           1'b0, 1'b1, 1'b0, 4'b1010, 4'b1010, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc("load b",           1'b0, 1'b1, 1'b0, 4'b0101, 4'b1010, 4'b0101, 1'b0, 1'b1, 1'b0, 1'b0);
        cyc("load third",       1'b0, 1'b1, 1'b0, 4'b1111, 4'b1111, 4'b0101, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc("inicia no pronto", 1'b0, 1'b0, 1'b1, 4'b0000, 4'b1111, 4'b0101, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc("idle after ign",   1'b0, 1'b0, 1'b0, 4'b0000, 4'b1111, 4'b0101, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc("carrega+inicia",   1'b0, 1'b1, 1'b1, 4'b0101, 4'b1111, 4'b0101, 1'b0, 1'b1, 1'b0, 1'b0);
        cyc("inicia dropped",   1'b0, 1'b0, 1'b0, 4'b0000, 4'b1111, 4'b0101, 1'b0, 1'b1, 1'b0, 1'b0);
        cyc("reload a",         1'b0, 1'b1, 1'b0, 4'b1010, 4'b1010, 4'b0101, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc("reload b",         1'b0, 1'b1, 1'b0, 4'b0101, 4'b1010, 4'b0101, 1'b0, 1'b1, 1'b0, 1'b0);

        run_seq("seq");
        run_seq("replay");

        for (int k = 0; k < 5; k++) begin
            cyc($sformatf("pre-reset k=%0d", k), 1'b0, 1'b0, (k == 0), 4'b0000,
                4'b1010, 4'b0101, (((k / 3) % 2) == 1), 1'b1, 1'b1, 1'b0);
        end
        cyc("reset mid",        1'b1, 1'b0, 1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc("no fim after rst", 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc("load after rst",   1'b0, 1'b1, 1'b0, 4'b0011, 4'b0011, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc("inicia after rst", 1'b0, 1'b0, 1'b1, 4'b0000, 4'b0011, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);

        bus.carrega = 1'b0;
        bus.inicia  = 1'b0;
        for (int k = 0; k < 10 && exp_q.size() != 0; k++) @(negedge clock);
        @(negedge clock);
        if (exp_q.size() != 0) begin
            $display("FAIL drain: got %0d pending snapshots, expected 0", exp_q.size());
            $fatal(1, "scoreboard did not drain");
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/seletor_alternado_n.md
Name: seletor_alternado_n

Overview:
- Upstream driver for mux2x1_n.
- Captures two N-bit operands from a serial load interface into internal registers and presents them on d0/d1.
- Sequences the mux select so each operand is shown for a fixed number of cycles, alternating, for a fixed number of repetitions.
- Flags end of sequence with a one-cycle pulse. Intended use is display sequencing in the memory-game datapath.

Parameters:
- BITS, 4: width of each operand; matches the mux BITS.
- DURACAO, 8: cycles sel holds each value per slot; must be >= 1.
- REPETICOES, 2: number of (sel=0, sel=1) pairs per sequence; must be >= 1.

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- carrega  input  1  load strobe, sampled at rising edge.
- dado_in  input  BITS  operand to load when carrega=1.
- inicia  input  1  start strobe, sampled at rising edge.
- d0  output  BITS  operand A register; feeds mux D0.
- d1  output  BITS  operand B register; feeds mux D1.
- sel  output  1  mux select, registered.
- pronto  output  1  both operands loaded.
- ocupado  output  1  sequence in progress.
- fim  output  1  one-cycle pulse when the sequence completes.

Behaviour:
- Single clock domain: clock. reset is synchronous, active-high.
- Reset values: d0=0, d1=0, sel=0, pronto=0, ocupado=0, fim=0; load pointer=0; FSM=OCIOSO; counters=0.
- Reset asserted mid-sequence overrides everything at that edge and applies the reset values.
- States:
  - OCIOSO: idle.
  - EXIBE_A: sel=0.
  - EXIBE_B: sel=1.
  - FINAL: single cycle, fim=1.
- Load, in OCIOSO only (carrega has priority over inicia in the same cycle; that inicia is dropped):
  - pointer 0: d0<=dado_in, pointer->1, pronto stays 0.
  - pointer 1: d1<=dado_in, pointer->2, pronto<=1.
  - pointer 2: d0<=dado_in, pointer->1, pronto<=0. This starts a new pair; d1 keeps its old value until overwritten.
- carrega outside OCIOSO is ignored; registers and pointer are unchanged.
- Start: inicia=1 in OCIOSO with pronto=1 and carrega=0.
  - Next state EXIBE_A; ocupado<=1, sel<=0, slot counter<=0, repetition counter<=0.
  - inicia with pronto=0 is ignored.
- EXIBE_A: slot counter increments each cycle. After the counter reaches DURACAO-1: sel<=1, counter<=0, go to EXIBE_B.
- EXIBE_B: same counting. After DURACAO cycles:
  - If repetition counter=REPETICOES-1: go to FINAL; sel<=0, ocupado<=0, fim<=1.
  - Otherwise: increment repetition counter, sel<=0, go to EXIBE_A.
- FINAL: fim=1 for exactly one cycle, then OCIOSO with fim<=0.
  - pronto stays 1, so the same pair can be replayed.
  - inicia/carrega during FINAL are ignored.
- Latency: ocupado=1 for exactly 2*DURACAO*REPETICOES cycles. fim rises on the edge where ocupado falls.
- inicia held high continuously: after FINAL, a new sequence starts from the first OCIOSO cycle in which inicia is sampled.
- d0/d1 are stable throughout a sequence.
- Counter widths: $clog2(DURACAO) and $clog2(REPETICOES), minimum 1 bit. No wrap occurs within a legal sequence.

Test Plan (BITS=4, DURACAO=3, REPETICOES=2):
- Reset for 2 cycles → d0=0000, d1=0000, sel=0, pronto=0, ocupado=0, fim=0.
- Load: carrega with dado_in=1010, then carrega with dado_in=0101 → d0=1010, d1=0101, pronto=1 after the 2nd edge. A 3rd carrega with 1111 → d0=1111, pronto=0.
- Sequence: load 1010/0101, pulse inicia at edge E0. Required:
  - sel=0 after E0..E2, sel=1 after E3..E5, sel=0 after E6..E8, sel=1 after E9..E11.
  - ocupado=0 and fim=1 after E12; fim=0 after E13. Mux output follows 1010,0101,1010,0101.
- Ignore cases: inicia with pronto=0 → no state change. carrega=1 at E4 during a sequence → d0/d1 unchanged. Simultaneous carrega+inicia in OCIOSO → load performed, ocupado stays 0.
- Reset at E5 of a running sequence → sel=0, ocupado=0, pronto=0, d0=d1=0000 after E5, with no fim pulse.
- Replay: after fim, pulse inicia again without reloading → identical 12-cycle sel pattern and a second fim pulse.
